tinyml_nn_soc_timestamp_logger: RTL and testbench
=================================================

# tinyml_nn_soc_timestamp_logger

Captures the free-running 48-bit cycle count whenever the NN accelerator signals start or done, and queues each capture as a 64-bit record in an internal FIFO. Software drains the FIFO through an AXI4 target port on the same interconnect as the cycle counter, giving per-inference latency without polling races. The block sits directly downstream of the SoC cycle counter and consumes its count value.

## Interface
- AXI_DATA_WIDTH, 64, data width; only 64 supported
- AXI_ID_WIDTH, 5, AXI ID width
- AXI_ADDR_WIDTH, 8, address width; only bits [3:3] decoded
- FIFO_DEPTH, 16, record entries; power of two, 4..256

- i_clk  in  1  single clock; count source shares it
- i_reset  in  1  synchronous, active-high
- i_cnt  in  48  cycle count from counter, same clock
- i_start  in  1  accelerator start pulse, one cycle
- i_done  in  1  accelerator done pulse, one cycle
- AR channel: o_axi4target_arready out 1; i_axi4target_arvalid/araddr/arid/arlen in; arburst/arsize/arcache/arlock/arprot/arqos/arregion/aruser in, ignored
- R channel: i_axi4target_rready in 1; o_axi4target_rvalid/rdata[63:0]/rid/rlast/rresp[1:0]/ruser out
- AW channel: o_axi4target_awready out; i_axi4target_awvalid/awaddr/awid/awlen in; remaining AW sidebands in, ignored
- W channel: o_axi4target_wready out; i_axi4target_wvalid/wdata/wlast/wstrb/wuser in
- B channel: o_axi4target_bvalid/bid/bresp[1:0]/buser out; i_axi4target_bready in

## Operation
- Capture: any cycle with i_start|i_done builds record {valid=1, ovf, code[1:0], seq[11:0], i_cnt}; bits [63],[62],[61:60],[59:48],[47:0]. Code 01 start, 10 done, 11 both same cycle (one record).
- seq: 12-bit counter incremented per captured-or-dropped event; wraps 0xFFF->0x000.
- FIFO full at capture: record dropped, sticky overflow set; seq still increments. ovf bit in each record = sticky overflow value at capture time.
- Address 0x00 read (DATA): non-empty -> head record returned and popped; empty -> rdata 0 (valid=0), no pop.
- Address 0x08 read (STATUS): rdata = {47'b0, overflow[16], count[15:0]} (count zero-extended), no side effect.
- Address 0x08 write, wstrb[0]=1 and wdata[0]=1: flush FIFO, clear overflow, clear seq. Other writes: no effect, bresp OKAY.
- arlen/awlen != 0: single beat returned / single beat consumed, rresp/bresp SLVERR (2'b10), no pop/flush. rlast always 1; ruser, buser 0.
- Simultaneous capture and pop: both happen, count unchanged; on full, pop frees a slot first, so the capture is kept.
- Simultaneous capture and flush: flush wins, capture discarded, seq cleared to 0.

## Timing
- Reset values: rvalid 0, bvalid 0, rdata 0, rid 0, bid 0, rresp/bresp 0, arready 1, awready 1, wready 1; FIFO empty, overflow 0, seq 0.
- arready = !rvalid; one outstanding read. AR accepted at edge N -> rvalid at N+1; data/pop decided at N. rvalid holds, data stable, until rready.
- awready = wready = !bvalid & awvalid & wvalid; AW and W accepted in the same cycle only. bvalid next cycle, held until bready.
- Capture latency: pulse at cycle N -> record in FIFO at N+1; visible to a read accepted at N+1.
- Reset mid-transaction: pending rvalid/bvalid drop in the reset cycle; FIFO content lost.

## Configuration
- TINYML_NN_TSLOG_SEQ_EN defined: seq counter built, bits [59:48] carry seq.
- Undefined: no seq counter, bits [59:48] read 0; all else identical.

## Structure
- Package tinyml_nn_soc_tslog_pkg: event codes (EV_START, EV_DONE, EV_BOTH), register offsets (DATA 0x00, STATUS 0x08), record field positions, RESP_OKAY/RESP_SLVERR.
- Sub-module tinyml_nn_soc_sync_fifo: parameterised width/depth, push/pop/flush, full/empty/count, same-cycle push+pop when full.

## Test plan
- i_cnt=0x1000, i_start pulse; then i_cnt=0x1400, i_done pulse; read 0x00 twice -> rdata 0x9000_0000_0000_1000 then 0xA001_0000_0000_1400; third read -> 0.
- i_start and i_done same cycle at i_cnt=0x55 -> one record, code 11, STATUS count=1.
- 17 start pulses, depth 16 -> STATUS = 0x1_0010; 16th record ovf=0; read all, then next event record ovf=1, seq=17.
- Full FIFO, capture and DATA read same cycle -> count stays 16, overflow stays 0.
- Write 0x08 wdata=1 while capture pulses -> STATUS 0, seq restarts 0; bvalid one cycle after AW/W, held with bready low.
- arlen=3 read of 0x00 -> single beat, rlast=1, rresp=SLVERR, count unchanged; rready held low 5 cycles -> rvalid and rdata stable, arready 0.

Source files
------------

// File: rtl/tinyml_nn_soc_tslog_pkg.sv
// Shared definitions for the timestamp logger: event codes, register
// offsets, record layout and AXI response codes.
package tinyml_nn_soc_tslog_pkg;

  // Event code carried in each record
  typedef enum logic [1:0] {
    EV_NONE  = 2'b00,
    EV_START = 2'b01,
    EV_DONE  = 2'b10,
    EV_BOTH  = 2'b11
  } ev_code_e;

  // Register offsets; only address bit 3 is decoded
  localparam logic [7:0] REG_DATA   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam int         REG_SEL_BIT = 3;

  // Record layout
  localparam int REC_W         = 64;
  localparam int REC_VALID_BIT = 63;
  localparam int REC_OVF_BIT   = 62;
  localparam int REC_CODE_LSB  = 60;
  localparam int REC_SEQ_LSB   = 48;
  localparam int REC_CNT_LSB   = 0;
  localparam int SEQ_W         = 12;
  localparam int CNT_W         = 48;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Map the two accelerator pulses onto an event code
  function automatic ev_code_e ev_code(input logic start, input logic done);
    return ev_code_e'({done, start});
  endfunction

endpackage

// File: rtl/tinyml_nn_soc_sync_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy count.
// A push while full is accepted when a pop happens in the same cycle.
// Flush empties the FIFO and overrides any push or pop in that cycle.
module tinyml_nn_soc_sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign pop_en  = i_pop & ~o_empty;
  assign push_en = i_push & (~o_full | pop_en);

  // Next-state for pointers, count and storage
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and no latch is inferred.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) begin
        mem_d[wr_ptr_q] = i_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage
  always_ff @(posedge i_clk) begin
    // NOTE: storage is deliberately not reset; the count and pointers alone decide which entries are live.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/tinyml_nn_soc_timestamp_logger.sv
// Timestamp logger: captures the cycle count on accelerator start/done
// pulses into a FIFO of 64-bit records, drained over an AXI4 target port.
// Optional build macro TINYML_NN_TSLOG_SEQ_EN adds the 12-bit sequence
// counter in record bits [59:48]; without it those bits read 0.
module tinyml_nn_soc_timestamp_logger
  import tinyml_nn_soc_tslog_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [47:0]                 i_cnt,
  input  logic                        i_start,
  input  logic                        i_done,
  // AR channel
  output logic                        o_axi4target_arready,
  input  logic                        i_axi4target_arvalid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_axi4target_araddr,
  input  logic [AXI_ID_WIDTH-1:0]     i_axi4target_arid,
  input  logic [7:0]                  i_axi4target_arlen,
  input  logic [1:0]                  i_axi4target_arburst,
  input  logic [2:0]                  i_axi4target_arsize,
  input  logic [3:0]                  i_axi4target_arcache,
  input  logic                        i_axi4target_arlock,
  input  logic [2:0]                  i_axi4target_arprot,
  input  logic [3:0]                  i_axi4target_arqos,
  input  logic [3:0]                  i_axi4target_arregion,
  input  logic                        i_axi4target_aruser,
  // R channel
  input  logic                        i_axi4target_rready,
  output logic                        o_axi4target_rvalid,
  output logic [AXI_DATA_WIDTH-1:0]   o_axi4target_rdata,
  output logic [AXI_ID_WIDTH-1:0]     o_axi4target_rid,
  output logic                        o_axi4target_rlast,
  output logic [1:0]                  o_axi4target_rresp,
  output logic                        o_axi4target_ruser,
  // AW channel
  output logic                        o_axi4target_awready,
  input  logic                        i_axi4target_awvalid,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_axi4target_awaddr,
  input  logic [AXI_ID_WIDTH-1:0]     i_axi4target_awid,
  input  logic [7:0]                  i_axi4target_awlen,
  input  logic [1:0]                  i_axi4target_awburst,
  input  logic [2:0]                  i_axi4target_awsize,
  input  logic [3:0]                  i_axi4target_awcache,
  input  logic                        i_axi4target_awlock,
  input  logic [2:0]                  i_axi4target_awprot,
  input  logic [3:0]                  i_axi4target_awqos,
  input  logic [3:0]                  i_axi4target_awregion,
  input  logic                        i_axi4target_awuser,
  // W channel
  output logic                        o_axi4target_wready,
  input  logic                        i_axi4target_wvalid,
  input  logic [AXI_DATA_WIDTH-1:0]   i_axi4target_wdata,
  input  logic                        i_axi4target_wlast,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_axi4target_wstrb,
  input  logic                        i_axi4target_wuser,
  // B channel
  output logic                        o_axi4target_bvalid,
  output logic [AXI_ID_WIDTH-1:0]     o_axi4target_bid,
  output logic [1:0]                  o_axi4target_bresp,
  output logic                        o_axi4target_buser,
  input  logic                        i_axi4target_bready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                      fifo_full, fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [REC_W-1:0]          fifo_head;
  logic [REC_W-1:0]          cap_rec;
  logic [SEQ_W-1:0]          seq_val;
  logic [AXI_DATA_WIDTH-1:0] status_word;

  logic                      ovf_q, ovf_d;
  logic                      rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic                      bvalid_q, bvalid_d;
  logic [AXI_ID_WIDTH-1:0]   bid_q, bid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic ev_any, ar_hs, aw_hs, rd_status, rd_err, wr_err;
  logic pop, flush, push, drop;

  // Handshakes and decode
  assign ev_any    = i_start | i_done;
  assign ar_hs     = i_axi4target_arvalid & ~rvalid_q;
  assign aw_hs     = i_axi4target_awvalid & i_axi4target_wvalid & ~bvalid_q;
  assign rd_status = (i_axi4target_araddr[REG_SEL_BIT] == REG_STATUS[REG_SEL_BIT]);
  assign rd_err    = (i_axi4target_arlen != 8'd0);
  assign wr_err    = (i_axi4target_awlen != 8'd0);

  // A DATA read pops only when it is a clean single beat and there is a record
  assign pop   = ar_hs & ~rd_status & ~rd_err & ~fifo_empty;
  assign flush = aw_hs & ~wr_err & (i_axi4target_awaddr[REG_SEL_BIT] == REG_STATUS[REG_SEL_BIT])
               & i_axi4target_wstrb[0] & i_axi4target_wdata[0];
  // Flush discards a same-cycle capture; a same-cycle pop makes room when full
  assign push  = ev_any & ~flush & (~fifo_full | pop);
  assign drop  = ev_any & ~flush & fifo_full & ~pop;

  assign status_word = AXI_DATA_WIDTH'({ovf_q, 16'(fifo_count)});

  // Assemble the capture record from the current count and logger state
  always_comb begin
    cap_rec                             = '0;
    cap_rec[REC_VALID_BIT]              = 1'b1;
    cap_rec[REC_OVF_BIT]                = ovf_q;
    cap_rec[REC_CODE_LSB +: 2]          = ev_code(i_start, i_done);
    cap_rec[REC_SEQ_LSB +: SEQ_W]       = seq_val;
    cap_rec[REC_CNT_LSB +: CNT_W]       = i_cnt;
  end

`ifdef TINYML_NN_TSLOG_SEQ_EN
  logic [SEQ_W-1:0] seq_q, seq_d;

  // Sequence counter: one step per event, kept or dropped; cleared by flush
  always_comb begin
    seq_d = seq_q;
    if (flush)       seq_d = '0;
    else if (ev_any) seq_d = seq_q + SEQ_W'(1);
  end

  // Sequence counter register
  always_ff @(posedge i_clk) begin
    if (i_reset) seq_q <= '0;
    else         seq_q <= seq_d;
  end

  assign seq_val = seq_q;
`else
  assign seq_val = '0;
`endif

  // Sticky overflow: set on a dropped capture, cleared only by flush
  always_comb begin
    ovf_d = ovf_q;
    if (flush)     ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
  end

  // Read response: data chosen at AR acceptance, held until rready
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rid_d    = i_axi4target_arid;
      if (rd_err) begin
        // Burst requests get one error beat carrying no data
        rresp_d = RESP_SLVERR;
        rdata_d = '0;
      end else begin
        rresp_d = RESP_OKAY;
        if (rd_status)        rdata_d = status_word;
        else if (!fifo_empty) rdata_d = fifo_head;
        else                  rdata_d = '0;
      end
    end else if (rvalid_q && i_axi4target_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // Write response: one cycle after the joint AW/W acceptance, held until bready
  always_comb begin
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    if (aw_hs) begin
      bvalid_d = 1'b1;
      bid_d    = i_axi4target_awid;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (bvalid_q && i_axi4target_bready) begin
      bvalid_d = 1'b0;
    end
  end

  // Logger and AXI response registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ovf_q    <= ovf_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
    end
  end

  tinyml_nn_soc_sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push),
    .i_data  (cap_rec),
    .i_pop   (pop),
    .i_flush (flush),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_axi4target_arready = ~rvalid_q;
  assign o_axi4target_rvalid  = rvalid_q;
  assign o_axi4target_rdata   = rdata_q;
  assign o_axi4target_rid     = rid_q;
  assign o_axi4target_rlast   = 1'b1;
  assign o_axi4target_rresp   = rresp_q;
  assign o_axi4target_ruser   = 1'b0;
  assign o_axi4target_awready = aw_hs;
  assign o_axi4target_wready  = aw_hs;
  assign o_axi4target_bvalid  = bvalid_q;
  assign o_axi4target_bid     = bid_q;
  assign o_axi4target_bresp   = bresp_q;
  assign o_axi4target_buser   = 1'b0;

  // Sideband and undecoded inputs are accepted but carry no meaning here
  logic unused_inputs;
  assign unused_inputs = ^{i_axi4target_araddr, i_axi4target_arburst, i_axi4target_arsize,
                           i_axi4target_arcache, i_axi4target_arlock, i_axi4target_arprot,
                           i_axi4target_arqos, i_axi4target_arregion, i_axi4target_aruser,
                           i_axi4target_awaddr, i_axi4target_awburst, i_axi4target_awsize,
                           i_axi4target_awcache, i_axi4target_awlock, i_axi4target_awprot,
                           i_axi4target_awqos, i_axi4target_awregion, i_axi4target_awuser,
                           i_axi4target_wdata, i_axi4target_wstrb, i_axi4target_wlast,
                           i_axi4target_wuser};

endmodule

// File: tb/tb_tinyml_nn_soc_timestamp_logger.sv
// Self-checking bench for the timestamp logger.
module tb_tinyml_nn_soc_timestamp_logger;
  import tinyml_nn_soc_tslog_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] cnt;
  logic        start, done;
  logic        arready, arvalid;
  logic [7:0]  araddr, arlen;
  logic [4:0]  arid;
  logic        rready, rvalid, rlast, ruser;
  logic [63:0] rdata;
  logic [4:0]  rid;
  logic [1:0]  rresp;
  logic        awready, awvalid;
  logic [7:0]  awaddr, awlen;
  logic [4:0]  awid;
  logic        wready, wvalid, wlast, wuser;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bvalid, buser, bready;
  logic [4:0]  bid;
  logic [1:0]  bresp;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tinyml_nn_soc_timestamp_logger dut (
    .i_clk(clk), .i_reset(rst), .i_cnt(cnt), .i_start(start), .i_done(done),
    .o_axi4target_arready(arready), .i_axi4target_arvalid(arvalid),
    .i_axi4target_araddr(araddr), .i_axi4target_arid(arid), .i_axi4target_arlen(arlen),
    .i_axi4target_arburst(2'b01), .i_axi4target_arsize(3'd3), .i_axi4target_arcache(4'd0),
    .i_axi4target_arlock(1'b0), .i_axi4target_arprot(3'd0), .i_axi4target_arqos(4'd0),
    .i_axi4target_arregion(4'd0), .i_axi4target_aruser(1'b0),
    .i_axi4target_rready(rready), .o_axi4target_rvalid(rvalid), .o_axi4target_rdata(rdata),
    .o_axi4target_rid(rid), .o_axi4target_rlast(rlast), .o_axi4target_rresp(rresp),
    .o_axi4target_ruser(ruser),
    .o_axi4target_awready(awready), .i_axi4target_awvalid(awvalid),
    .i_axi4target_awaddr(awaddr), .i_axi4target_awid(awid), .i_axi4target_awlen(awlen),
    .i_axi4target_awburst(2'b01), .i_axi4target_awsize(3'd3), .i_axi4target_awcache(4'd0),
    .i_axi4target_awlock(1'b0), .i_axi4target_awprot(3'd0), .i_axi4target_awqos(4'd0),
    .i_axi4target_awregion(4'd0), .i_axi4target_awuser(1'b0),
    .o_axi4target_wready(wready), .i_axi4target_wvalid(wvalid), .i_axi4target_wdata(wdata),
    .i_axi4target_wlast(wlast), .i_axi4target_wstrb(wstrb), .i_axi4target_wuser(wuser),
    .o_axi4target_bvalid(bvalid), .o_axi4target_bid(bid), .o_axi4target_bresp(bresp),
    .o_axi4target_buser(buser), .i_axi4target_bready(bready)
  );

  typedef struct {
    logic        s;
    logic        d;
    logic [47:0] c;
    logic [4:0]  id;
    logic [63:0] exp;   // expected record with seq field zero
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h", name, act, exp);
    end
  endtask

  // Sequence field contribution for the current build
  function automatic logic [63:0] seqf(input int s);
`ifdef TINYML_NN_TSLOG_SEQ_EN
    return 64'(s & 'hFFF) << 48;
`else
    return 64'd0 & 64'(s);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic d, input logic [47:0] c);
    start = s; done = d; cnt = c;
    step();
    start = 1'b0; done = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [7:0] l, input logic [4:0] id,
                          output logic [63:0] data, output logic [1:0] resp, output logic [4:0] gid);
    int n;
    arvalid = 1'b1; araddr = a; arlen = l; arid = id;
    #1;
    n = 0;
    while (!arready && n < 16) begin step(); n++; end
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin step(); n++; end
    check("rd_rvalid", rvalid, 1);
    check("rd_rlast", rlast, 1);
    data = rdata; resp = rresp; gid = rid;
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s,
                           input logic [7:0] l, input logic [4:0] id,
                           output logic [1:0] resp, output logic [4:0] gid);
    int n;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d; wstrb = s; awlen = l; awid = id; wlast = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 16) begin step(); n++; end
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 16) begin step(); n++; end
    check("wr_bvalid", bvalid, 1);
    resp = bresp; gid = bid;
    bready = 1'b1;
    step();
    bready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    logic [4:0]  g;

    vt[0] = '{s: 1'b1, d: 1'b0, c: 48'h1000,         id: 5'h01, exp: 64'h9000_0000_0000_1000};
    vt[1] = '{s: 1'b0, d: 1'b1, c: 48'h1400,         id: 5'h02, exp: 64'hA000_0000_0000_1400};
    vt[2] = '{s: 1'b1, d: 1'b1, c: 48'h55,           id: 5'h1F, exp: 64'hB000_0000_0000_0055};
    vt[3] = '{s: 1'b1, d: 1'b0, c: 48'hFFFF_FFFF_FFFF, id: 5'h10, exp: 64'h9000_FFFF_FFFF_FFFF};

    // Reset; AW/W valid held high to observe the ready path
    rst = 1'b1; cnt = '0; start = 0; done = 0;
    arvalid = 0; araddr = 0; arlen = 0; arid = 0; rready = 0;
    awvalid = 1; wvalid = 1; awaddr = 0; awlen = 0; awid = 0; wdata = 0; wstrb = 0; wlast = 0; wuser = 0;
    bready = 0;
    repeat (3) step();
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_wready", wready, 1);
    awvalid = 0; wvalid = 0;
    rst = 1'b0;
    step();
    axi_read(REG_STATUS, 8'd0, 5'd3, d, r, g);
    check("rst_status", d, 64'h0);

    // Table: capture each vector, then drain in order
    foreach (vt[i]) pulse(vt[i].s, vt[i].d, vt[i].c);
    axi_read(REG_STATUS, 8'd0, 5'd4, d, r, g);
    check("tab_status", d, 64'h4);
    for (int i = 0; i < 4; i++) begin
      axi_read(REG_DATA, 8'd0, vt[i].id, d, r, g);
      check($sformatf("tab_rec%0d", i), d, vt[i].exp | seqf(i));
      check($sformatf("tab_rid%0d", i), g, vt[i].id);
      check($sformatf("tab_rresp%0d", i), r, RESP_OKAY);
    end
    axi_read(REG_DATA, 8'd0, 5'd5, d, r, g);
    check("empty_read", d, 64'h0);

    // Both pulses in one cycle after a flush
    axi_write(REG_STATUS, 64'h1, 8'hFF, 8'd0, 5'd6, r, g);
    pulse(1'b1, 1'b1, 48'h55);
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("both_status", d, 64'h1);
    axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
    check("both_rec", d, 64'hB000_0000_0000_0055);

    // Overflow: 17 events into 16 entries
    axi_write(REG_STATUS, 64'h1, 8'hFF, 8'd0, 5'd7, r, g);
    for (int i = 0; i < 17; i++) pulse(1'b1, 1'b0, 48'h2000 + 48'(i));
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("ovf_status", d, 64'h1_0010);
    for (int i = 0; i < 16; i++) begin
      axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
      check($sformatf("ovf_rec%0d", i), d, (64'h9000_0000_0000_2000 + 64'(i)) | seqf(i));
    end
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("ovf_status_drained", d, 64'h1_0000);
    pulse(1'b1, 1'b0, 48'h3000);
    axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
    check("ovf_next_rec", d, 64'hD000_0000_0000_3000 | seqf(17));

    // Full FIFO: capture and pop in the same cycle
    axi_write(REG_STATUS, 64'h1, 8'hFF, 8'd0, 5'd8, r, g);
    for (int i = 0; i < 16; i++) pulse(1'b1, 1'b0, 48'h5000 + 48'(i));
    arvalid = 1; araddr = REG_DATA; arlen = 0; arid = 5'h09;
    start = 1; cnt = 48'h4000;
    step();
    arvalid = 0; start = 0;
    check("fullpop_rvalid", rvalid, 1);
    check("fullpop_rec", rdata, 64'h9000_0000_0000_5000 | seqf(0));
    rready = 1; step(); rready = 0;
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("fullpop_status", d, 64'h10);
    for (int i = 1; i <= 16; i++) begin
      axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
      if (i < 16) check($sformatf("fullpop_drain%0d", i), d, (64'h9000_0000_0000_5000 + 64'(i)) | seqf(i));
      else        check("fullpop_last", d, 64'h9000_0000_0000_4000 | seqf(16));
    end

    // Flush write racing a capture; bvalid held while bready low
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 48'h6000 + 48'(i));
    awvalid = 1; wvalid = 1; awaddr = REG_STATUS; awlen = 0; awid = 5'h0A;
    wdata = 64'h1; wstrb = 8'hFF; wlast = 1;
    start = 1; cnt = 48'h6100;
    #1;
    check("flush_awready", awready, 1);
    check("flush_wready", wready, 1);
    step();
    awvalid = 0; wvalid = 0; start = 0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("flush_bvalid_hold%0d", i), bvalid, 1);
      step();
    end
    check("flush_bid", bid, 5'h0A);
    check("flush_bresp", bresp, RESP_OKAY);
    bready = 1; step(); bready = 0;
    check("flush_bvalid_clear", bvalid, 0);
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("flush_status", d, 64'h0);
    pulse(1'b1, 1'b0, 48'h7000);

    // Writes that must not flush
    axi_write(REG_STATUS, 64'h2, 8'hFF, 8'd0, 5'd1, r, g);
    check("nf_bit0_resp", r, RESP_OKAY);
    axi_write(REG_DATA, 64'h1, 8'hFF, 8'd0, 5'd2, r, g);
    check("nf_data_resp", r, RESP_OKAY);
    axi_write(REG_STATUS, 64'h1, 8'hFE, 8'd0, 5'd3, r, g);
    check("nf_strb_resp", r, RESP_OKAY);
    axi_write(REG_STATUS, 64'h1, 8'hFF, 8'd1, 5'd4, r, g);
    check("nf_burst_resp", r, RESP_SLVERR);
    check("nf_burst_bid", g, 5'd4);
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("nf_status", d, 64'h1);
    axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
    check("post_flush_rec", d, 64'h9000_0000_0000_7000);

    // Burst read: one error beat, no pop, stable under back-pressure
    pulse(1'b1, 1'b0, 48'h8000);
    arvalid = 1; araddr = REG_DATA; arlen = 8'd3; arid = 5'h0B;
    step();
    arvalid = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("burst_rvalid%0d", i), rvalid, 1);
      check($sformatf("burst_rdata%0d", i), rdata, 64'h0);
      check($sformatf("burst_arready%0d", i), arready, 0);
      step();
    end
    check("burst_rresp", rresp, RESP_SLVERR);
    check("burst_rlast", rlast, 1);
    check("burst_rid", rid, 5'h0B);
    rready = 1; step(); rready = 0;
    check("burst_rvalid_clear", rvalid, 0);
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("burst_status", d, 64'h1);
    axi_read(REG_DATA, 8'd0, 5'd0, d, r, g);
    check("burst_rec", d, 64'h9000_0000_0000_8000 | seqf(1));

    // Reset while both responses are pending
    pulse(1'b1, 1'b0, 48'h9000);
    awvalid = 1; wvalid = 1; awaddr = REG_DATA; awlen = 0; wdata = 0;
    arvalid = 1; araddr = REG_STATUS; arlen = 0;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("mid_rvalid", rvalid, 1);
    check("mid_bvalid", bvalid, 1);
    rst = 1; step(); rst = 0;
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_bvalid", bvalid, 0);
    axi_read(REG_STATUS, 8'd0, 5'd0, d, r, g);
    check("mid_rst_status", d, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
